// File: rtl/mode_sequencer_if.sv
// Front-panel bus between the board/function modules and mode_sequencer.
// master = board and function-module side, slave = the sequencer itself.
interface mode_sequencer_if #(
   parameter int NUM_MODES = 7,
   parameter int DISP_W    = 48
);
   logic [5:0]                  btn_n_i;
   logic [NUM_MODES-1:0]        norm_i;
   logic [NUM_MODES*DISP_W-1:0] disp_i;
   logic [NUM_MODES-1:0]        alarm_req_i;
   logic [NUM_MODES-1:0]        mode_o;
   logic [5:0]                  btn_p_o;
   logic [DISP_W-1:0]           out;
   logic [7:0]                  o_m;
   logic                        alarm;

   modport master (
      output btn_n_i, norm_i, disp_i, alarm_req_i,
      input  mode_o, btn_p_o, out, o_m, alarm
   );

   modport slave (
      input  btn_n_i, norm_i, disp_i, alarm_req_i,
      output mode_o, btn_p_o, out, o_m, alarm
   );
endinterface

// File: rtl/mode_sequencer.sv
// Watch front-panel controller: button conditioning, one-hot mode rotation,
// display mux and latched alarms. Optional MODE_AUTO_JUMP_EN jumps to an alarming mode.
module mode_sequencer #(
   parameter int NUM_MODES = 7,
   parameter int DISP_W    = 48,
   parameter int DEB_CYC   = 16
) (
   input logic             clk,
   input logic             rst,
   mode_sequencer_if.slave bus
);
   localparam int             CNT_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);
   localparam logic [3:0]       LAST    = 4'(NUM_MODES - 1);

   logic [5:0]           btn_p;
   logic [3:0]           idx_reg, idx_next, disp_idx_reg;
   logic [NUM_MODES-1:0] mode_reg, mode_next;
   logic [NUM_MODES-1:0] pend_reg, pend_next, req_prev_reg, rise, esc_clr;
   logic [DISP_W-1:0]    out_reg, disp_sel;
   logic                 norm_cur, alarm_w;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         logic             s1_reg, s2_reg, deb_reg, p_reg;
         logic [CNT_W-1:0] cnt_reg;

         // Level is accepted only after DEB_CYC consecutive disagreeing cycles.
         always_ff @(posedge clk) begin
            if (rst) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               deb_reg <= 1'b0;
               p_reg   <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= ~bus.btn_n_i[gi];
               s2_reg <= s1_reg;
               p_reg  <= 1'b0;
               if (s2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_MAX) begin
                  deb_reg <= s2_reg;
                  p_reg   <= s2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign btn_p[gi] = p_reg;
      end

      for (gi = 0; gi < NUM_MODES; gi++) begin : g_onehot
         assign mode_next[gi] = (idx_next == 4'(gi));
      end
   endgenerate

   always_comb begin
      rise     = bus.alarm_req_i & ~req_prev_reg;
      norm_cur = |(bus.norm_i & mode_reg);
      idx_next = idx_reg;
      if (norm_cur && (btn_p[0] ^ btn_p[1])) begin
         if (btn_p[0])
            idx_next = (idx_reg == LAST) ? 4'd0 : idx_reg + 4'd1;
         else
            idx_next = (idx_reg == 4'd0) ? LAST : idx_reg - 4'd1;
      end
`ifdef MODE_AUTO_JUMP_EN
      // Descending scan so the lowest rising request wins.
      if (norm_cur) begin
         for (int k = NUM_MODES - 1; k >= 0; k--) begin
            if (rise[k]) idx_next = 4'(k);
         end
      end
`endif
      esc_clr   = btn_p[5] ? mode_reg : '0;
      pend_next = (pend_reg & ~esc_clr) | rise;
   end

   always_comb begin
      disp_sel = '0;
      for (int k = 0; k < NUM_MODES; k++) begin
         if (mode_reg[k]) disp_sel = bus.disp_i[k*DISP_W +: DISP_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg      <= 4'd0;
         mode_reg     <= NUM_MODES'(1);
         pend_reg     <= '0;
         req_prev_reg <= '0;
         out_reg      <= '0;
         disp_idx_reg <= 4'd0;
      end else begin
         idx_reg      <= idx_next;
         mode_reg     <= mode_next;
         pend_reg     <= pend_next;
         req_prev_reg <= bus.alarm_req_i;
         out_reg      <= disp_sel;
         disp_idx_reg <= idx_reg;
      end
   end

   assign alarm_w     = |pend_reg;
   assign bus.mode_o  = mode_reg;
   assign bus.btn_p_o = btn_p;
   assign bus.out     = out_reg;
   assign bus.alarm   = alarm_w;
   assign bus.o_m     = {alarm_w, 3'b000, disp_idx_reg};
endmodule
